icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction fetcher (upstream of this block's response path) and the memory controller.
- Accepts one word-fetch request at a time from the fetcher via the start_fetch / fetch_ready handshake.
- Hits return in 1 cycle. Misses fill a whole line from memory, one word per memory transaction, then return the requested word.
- A ROB clear-up aborts the in-flight request without corrupting cache contents.

Parameters:
INDEX_BITS, 4, number of lines = 2^INDEX_BITS
WORD_SEL_BITS, 2, words per line = 2^WORD_SEL_BITS (line = 16 bytes at default)

Ports:
clk_in  input  1  system clock; all state updates on rising edge
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  global ready; when low, all state and outputs hold
rob_clear_up  input  1  flush: abandon current fetch request
pc  input  32  fetch address from fetcher; bits [1:0] ignored
start_fetch  input  1  fetcher request level, held until fetch_ready seen
fetch_ready  output  1  one-cycle pulse: inst/inst_addr valid
inst  output  32  fetched instruction word
inst_addr  output  32  address of inst (pc with [1:0]=0)
mem_req  output  1  word-read request to memory controller, held until mem_ready
mem_addr  output  32  word-aligned read address, stable while mem_req=1
mem_ready  input  1  one-cycle pulse: mem_data valid, request done
mem_data  input  32  returned word

Behaviour:
Address split:
- offset = pc[1:0] (ignored)
- word = pc[WORD_SEL_BITS+1:2]
- index = next INDEX_BITS bits
- tag = remaining upper bits

Storage and reset:
- Storage: per-line valid bit, tag, and 2^WORD_SEL_BITS data words.
- Reset: all valid=0; state IDLE; fetch_ready=0, inst=0, inst_addr=0, mem_req=0, mem_addr=0. Data/tag arrays need no reset.
- rdy_in=0: nothing changes, including mem_ready/mem_data sampling. The memory controller is gated by the same rdy_in.

States: IDLE, FILL, DRAIN. All outputs are registered.

IDLE:
- Accept a request when start_fetch=1 && fetch_ready=0 && rob_clear_up=0. The fetch_ready=0 qualifier blocks re-acceptance in the cycle the fetcher still holds start_fetch after a response.
- Request latched as req_addr = {pc[31:2],2'b00}.
- Hit (valid && tag match): next cycle fetch_ready=1, inst=word, inst_addr=req_addr; stay IDLE. Latency is 1 cycle.
- Miss: clear the line's valid bit. Set mem_req=1, mem_addr = {tag,index,word 0,2'b00}, fill counter=0. Go to FILL.

FILL:
- On mem_ready: write mem_data into word[counter] of the line; deassert mem_req for exactly one cycle.
- If counter < last: counter+1, then reassert mem_req with mem_addr+4.
- After the last word: set valid, write tag. Next cycle fetch_ready=1 with the requested word (taken from the array or bypassed from mem_data if it was the last word). Go IDLE.

fetch_ready rule: high for exactly one cycle per accepted, unflushed request, then 0.

Flush (rob_clear_up=1) in any state:
- fetch_ready forced 0 next cycle. A hit response due next cycle is suppressed.
- IDLE: no acceptance this cycle.
- FILL with mem_req=1 and mem_ready not yet seen: go to DRAIN, keep mem_req/mem_addr stable.
- FILL with mem_req=0 (between words): drop to IDLE.
- Line stays invalid in both FILL cases (partial fill discarded).
- Flush coinciding with the final mem_ready: data and tag written, valid set, no response, go IDLE.

DRAIN:
- Wait for mem_ready, discard the data, mem_req=0, go IDLE.
- A new start_fetch is not accepted until IDLE.

Other rules:
- Reset mid-fill: immediate return to reset values; the memory controller is reset by the same rst_in.
- Exactly one memory transaction outstanding at a time.
- The cache is never written by stores. Self-modifying code is unsupported.

Decomposition:
- Shared constants header: ICACHE_INDEX_BITS, ICACHE_WORD_SEL_BITS defaults, and state encodings IDLE=2'd0, FILL=2'd1, DRAIN=2'd2.
- One natural sub-module: icache_line_array. It holds valid/tag/data storage with a combinational read by index and a single write port for word, tag and valid updates. The controller FSM stays in icache_direct.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, start_fetch=1, pc=0x0000_1004, memory returns 0xA0,0xA1,0xA2,0xA3 for 0x1000..0x100C.
   - Response: four mem_req cycles with mem_addr 0x1000,0x1004,0x1008,0x100C, then one fetch_ready with inst=0xA1 and inst_addr=0x1004.
2. Hit:
   - Stimulus: after test 1, pc=0x100C.
   - Response: fetch_ready exactly 1 cycle after acceptance, inst=0xA3, and no mem_req.
3. Conflict:
   - Stimulus: pc=0x1104 (same index, different tag).
   - Response: refill from 0x1100. A following fetch of 0x1004 misses again.
4. Flush mid-fill:
   - Stimulus: rob_clear_up pulsed during the second word's request.
   - Response: mem_req held until mem_ready, then 0. No fetch_ready is issued, and a later fetch of the same line misses and refetches all 4 words.
5. Handshake and stall:
   - Stimulus: start_fetch held high through a response; then rdy_in=0 for 5 cycles during FILL.
   - Response: only one fetch_ready per request; mem_req, mem_addr and the fill counter are frozen during the stall and the fill completes correctly afterwards.
6. Flush vs hit:
   - Stimulus: rob_clear_up in the same cycle a hit would respond.
   - Response: fetch_ready stays 0, and a new pc on the following cycle is served normally.

Source files
------------

// File: rtl/icache_direct_pkg.sv
// Shared geometry defaults and controller state encoding for the direct-mapped instruction cache.
package icache_direct_pkg;

  localparam int ICACHE_INDEX_BITS    = 4;
  localparam int ICACHE_WORD_SEL_BITS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Line storage: per-line valid bit, tag and data words. Combinational read by index,
// one write port that can update a data word and/or the tag+valid of a line.
module icache_line_array #(
  parameter int INDEX_BITS    = 4,
  parameter int WORD_SEL_BITS = 2,
  parameter int TAG_BITS      = 26
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [INDEX_BITS-1:0]    rd_idx,
  input  logic [WORD_SEL_BITS-1:0] rd_word,
  output logic                     rd_valid,
  output logic [TAG_BITS-1:0]      rd_tag,
  output logic [31:0]              rd_data,
  input  logic                     wr_data_en,
  input  logic                     wr_meta_en,
  input  logic [INDEX_BITS-1:0]    wr_idx,
  input  logic [WORD_SEL_BITS-1:0] wr_word,
  input  logic [31:0]              wr_data,
  input  logic [TAG_BITS-1:0]      wr_tag,
  input  logic                     wr_valid
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int WORDS = 1 << WORD_SEL_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES][WORDS];

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx][rd_word];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (wr_meta_en) begin
      valid[wr_idx] <= wr_valid;
    end
  end

  // Tags and data are only trusted behind a valid bit, so they carry no reset.
  always_ff @(posedge clk_in) begin
    if (wr_meta_en) begin
      tags[wr_idx] <= wr_tag;
    end
    if (wr_data_en) begin
      data[wr_idx][wr_word] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, whole-line fills one word per
// memory transaction, and flush handling that never leaves a partially filled line valid.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS    = ICACHE_INDEX_BITS,
  parameter int WORD_SEL_BITS = ICACHE_WORD_SEL_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear_up,
  input  logic [31:0] pc,
  input  logic        start_fetch,
  output logic        fetch_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
);

  localparam int LINE_LSB = WORD_SEL_BITS + 2;
  localparam int TAG_LSB  = LINE_LSB + INDEX_BITS;
  localparam int TAG_BITS = 32 - TAG_LSB;
  localparam logic [WORD_SEL_BITS-1:0] LAST_WORD = '1;

  // Handshakes: the fetcher holds start_fetch until it sees the one-cycle fetch_ready pulse;
  // mem_req is held with a stable mem_addr until the one-cycle mem_ready pulse completes it.
  icache_state_e state, state_d;
  logic [31:0] req_addr, req_addr_d;
  logic [WORD_SEL_BITS-1:0] fill_cnt, fill_cnt_d;
  logic fetch_ready_d, mem_req_d;
  logic [31:0] inst_d, inst_addr_d, mem_addr_d;

  logic [INDEX_BITS-1:0] rd_idx, wr_idx;
  logic [WORD_SEL_BITS-1:0] rd_word, wr_word;
  logic rd_valid, wr_data_en, wr_meta_en, wr_valid;
  logic [TAG_BITS-1:0] rd_tag, wr_tag;
  logic [31:0] rd_data, wr_data;
  logic accept, hit, beat_done, last_beat;
  logic unused_pc;

  assign unused_pc = ^pc[1:0];
  assign accept    = (state == IDLE) && start_fetch && !fetch_ready && !rob_clear_up;
  assign rd_idx    = (state == IDLE) ? pc[LINE_LSB +: INDEX_BITS] : req_addr[LINE_LSB +: INDEX_BITS];
  assign rd_word   = (state == IDLE) ? pc[2 +: WORD_SEL_BITS] : req_addr[2 +: WORD_SEL_BITS];
  assign hit       = rd_valid && (rd_tag == pc[31:TAG_LSB]);
  assign beat_done = (state == FILL) && mem_req && mem_ready;
  assign last_beat = beat_done && (fill_cnt == LAST_WORD);

  icache_line_array #(
    .INDEX_BITS   (INDEX_BITS),
    .WORD_SEL_BITS(WORD_SEL_BITS),
    .TAG_BITS     (TAG_BITS)
  ) u_lines (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_idx    (rd_idx),
    .rd_word   (rd_word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_data_en(wr_data_en && rdy_in),
    .wr_meta_en(wr_meta_en && rdy_in),
    .wr_idx    (wr_idx),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .wr_tag    (wr_tag),
    .wr_valid  (wr_valid)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      req_addr    <= '0;
      fill_cnt    <= '0;
      fetch_ready <= 1'b0;
      inst        <= '0;
      inst_addr   <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else if (rdy_in) begin
      state       <= state_d;
      req_addr    <= req_addr_d;
      fill_cnt    <= fill_cnt_d;
      fetch_ready <= fetch_ready_d;
      inst        <= inst_d;
      inst_addr   <= inst_addr_d;
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (accept && !hit) state_d = FILL;
      FILL: begin
        if (beat_done) begin
          if (rob_clear_up || last_beat) state_d = IDLE;
        end else if (rob_clear_up) begin
          // An outstanding memory read must still be absorbed before going idle.
          state_d = mem_req ? DRAIN : IDLE;
        end
      end
      DRAIN: if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_addr_d    = req_addr;
    fill_cnt_d    = fill_cnt;
    fetch_ready_d = 1'b0;
    inst_d        = inst;
    inst_addr_d   = inst_addr;
    mem_req_d     = mem_req;
    mem_addr_d    = mem_addr;
    wr_data_en    = 1'b0;
    wr_meta_en    = 1'b0;
    wr_valid      = 1'b0;
    wr_idx        = req_addr[LINE_LSB +: INDEX_BITS];
    wr_word       = fill_cnt;
    wr_data       = mem_data;
    wr_tag        = req_addr[31:TAG_LSB];
    unique case (state)
      IDLE: begin
        if (accept) begin
          req_addr_d = {pc[31:2], 2'b00};
          if (hit) begin
            fetch_ready_d = 1'b1;
            inst_d        = rd_data;
            inst_addr_d   = {pc[31:2], 2'b00};
          end else begin
            wr_meta_en = 1'b1;
            wr_idx     = pc[LINE_LSB +: INDEX_BITS];
            wr_tag     = pc[31:TAG_LSB];
            mem_req_d  = 1'b1;
            mem_addr_d = {pc[31:LINE_LSB], {LINE_LSB{1'b0}}};
            fill_cnt_d = '0;
          end
        end
      end
      FILL: begin
        if (beat_done) begin
          wr_data_en = 1'b1;
          mem_req_d  = 1'b0;
          if (last_beat) begin
            wr_meta_en = 1'b1;
            wr_valid   = 1'b1;
            if (!rob_clear_up) begin
              fetch_ready_d = 1'b1;
              // The requested word is either already in the array or arriving right now.
              inst_d        = (req_addr[2 +: WORD_SEL_BITS] == LAST_WORD) ? mem_data : rd_data;
              inst_addr_d   = req_addr;
            end
          end else begin
            fill_cnt_d = fill_cnt + WORD_SEL_BITS'(1);
          end
        end else if (!mem_req && !rob_clear_up) begin
          mem_req_d  = 1'b1;
          mem_addr_d = mem_addr + 32'd4;
        end
      end
      DRAIN: if (mem_ready) mem_req_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: a vector table of fetches plus hand-written flush,
// stall and reset sequences against a fixed-latency memory model.
module tb_icache_direct;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_addr;
    int          exp_beats;
    logic [31:0] exp_base;
    int          stall_beat;
  } vec_t;

  localparam int MEM_LAT = 3;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear_up, start_fetch;
  logic [31:0] pc;
  logic        fetch_ready, mem_req, mem_ready;
  logic [31:0] inst, inst_addr, mem_addr, mem_data;

  int n_vec = 0;
  int n_fail = 0;
  int ready_cnt = 0;
  logic rdy_q = 1'b1;
  logic rst_q = 1'b1;
  logic [31:0] mem_log[$];
  logic [31:0] exp_q[$];
  vec_t vecs[9];

  icache_direct dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .rob_clear_up(rob_clear_up),
    .pc          (pc),
    .start_fetch (start_fetch),
    .fetch_ready (fetch_ready),
    .inst        (inst),
    .inst_addr   (inst_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data)
  );

  // Clock and reset-related sampling
  always #5 clk_in = ~clk_in;

  initial begin
    forever begin
      @(posedge clk_in);
      rdy_q = rdy_in;
      rst_q = rst_in;
    end
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000100) return 32'h0000_00A0 + 32'(a[3:2]);
    return {16'hBEEF, a[15:0]};
  endfunction

  // Memory controller model: fixed latency, gated by the same rdy_in and rst_in.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk_in);
      if (rst_q) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end else if (rdy_q) begin
        if (mem_ready) begin
          mem_ready = 1'b0;
        end else if (mem_req) begin
          if (wait_cnt >= MEM_LAT) begin
            mem_ready = 1'b1;
            mem_data  = mem_word(mem_addr);
            mem_log.push_back(mem_addr);
            wait_cnt  = 0;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_in);
      if (fetch_ready === 1'b1) ready_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Driver: one fetch, start_fetch held one cycle past the response.
  task automatic do_fetch(input vec_t v);
    int n0, r0, lat;
    bit got, stalled;
    logic [31:0] snap;
    n0 = mem_log.size();
    r0 = ready_cnt;
    got = 1'b0;
    stalled = 1'b0;
    lat = 0;
    pc = v.pc;
    start_fetch = 1'b1;
    for (int cyc = 1; cyc <= 300 && !got; cyc++) begin
      @(negedge clk_in);
      if (fetch_ready === 1'b1) begin
        got = 1'b1;
        lat = cyc;
      end else if (v.stall_beat >= 0 && !stalled && mem_req &&
                   mem_addr == v.exp_base + 32'(4 * v.stall_beat)) begin
        stalled = 1'b1;
        snap = mem_addr;
        rdy_in = 1'b0;
        repeat (5) begin
          @(negedge clk_in);
          check_bit("stall_mem_req", mem_req, 1'b1);
          check("stall_mem_addr", mem_addr, snap);
        end
        rdy_in = 1'b1;
      end
    end
    check_bit("fetch_ready_seen", got, 1'b1);
    check("inst", inst, v.exp_inst);
    check("inst_addr", inst_addr, v.exp_addr);
    if (v.exp_beats == 0) check("hit_latency", 32'(lat), 32'd1);
    @(negedge clk_in);
    check_bit("ready_one_cycle", fetch_ready, 1'b0);
    start_fetch = 1'b0;
    repeat (2) @(negedge clk_in);
    check("ready_pulses", 32'(ready_cnt - r0), 32'd1);
    check("mem_beats", 32'(mem_log.size() - n0), 32'(v.exp_beats));
    for (int i = 0; i < v.exp_beats; i++) exp_q.push_back(v.exp_base + 32'(4 * i));
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("mem_addr_seq", (n0 + i < mem_log.size()) ? mem_log[n0 + i] : 32'hDEAD_DEAD, e);
    end
  endtask

  initial begin
    int n0, r0;
    bit found, done;
    vec_t v;

    vecs[0] = '{32'h0000_1004, 32'h0000_00A1, 32'h0000_1004, 4, 32'h0000_1000, -1};
    vecs[1] = '{32'h0000_100C, 32'h0000_00A3, 32'h0000_100C, 0, 32'h0000_1000, -1};
    vecs[2] = '{32'h0000_1000, 32'h0000_00A0, 32'h0000_1000, 0, 32'h0000_1000, -1};
    vecs[3] = '{32'h0000_1104, 32'hBEEF_1104, 32'h0000_1104, 4, 32'h0000_1100, -1};
    vecs[4] = '{32'h0000_1004, 32'h0000_00A1, 32'h0000_1004, 4, 32'h0000_1000, -1};
    vecs[5] = '{32'h0000_203C, 32'hBEEF_203C, 32'h0000_203C, 4, 32'h0000_2030, -1};
    vecs[6] = '{32'h0000_2030, 32'hBEEF_2030, 32'h0000_2030, 0, 32'h0000_2030, -1};
    vecs[7] = '{32'h0000_1006, 32'h0000_00A1, 32'h0000_1004, 0, 32'h0000_1000, -1};
    vecs[8] = '{32'h0000_4054, 32'hBEEF_4054, 32'h0000_4054, 4, 32'h0000_4050, 1};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    rob_clear_up = 1'b0;
    start_fetch = 1'b0;
    pc = '0;
    repeat (3) @(negedge clk_in);
    check_bit("rst_fetch_ready", fetch_ready, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_addr", inst_addr, 32'h0);
    check_bit("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);

    for (int i = 0; i < 9; i++) do_fetch(vecs[i]);

    // Flush while the second word's read is outstanding: drain, no response, line stays invalid.
    n0 = mem_log.size();
    r0 = ready_cnt;
    pc = 32'h0000_3048;
    start_fetch = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_in);
      if (mem_req && mem_addr == 32'h0000_3044) found = 1'b1;
    end
    check_bit("flush_word1_req_seen", found, 1'b1);
    rob_clear_up = 1'b1;
    start_fetch = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_in);
      rob_clear_up = 1'b0;
      if (mem_log.size() == n0 + 2) begin
        done = 1'b1;
      end else begin
        check_bit("drain_mem_req_held", mem_req, 1'b1);
        check("drain_mem_addr_held", mem_addr, 32'h0000_3044);
      end
    end
    check_bit("drain_completed", done, 1'b1);
    repeat (3) @(negedge clk_in);
    check_bit("drain_mem_req_low", mem_req, 1'b0);
    check("drain_beats", 32'(mem_log.size() - n0), 32'd2);
    check("drain_no_response", 32'(ready_cnt - r0), 32'd0);
    v = '{32'h0000_3048, 32'hBEEF_3048, 32'h0000_3048, 4, 32'h0000_3040, -1};
    do_fetch(v);

    // Flush landing on the final mem_ready: line becomes valid but no response.
    n0 = mem_log.size();
    r0 = ready_cnt;
    pc = 32'h0000_5064;
    start_fetch = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_in);
      if (mem_req && mem_addr == 32'h0000_506C) found = 1'b1;
    end
    check_bit("final_req_seen", found, 1'b1);
    repeat (MEM_LAT) @(negedge clk_in);
    rob_clear_up = 1'b1;
    start_fetch = 1'b0;
    @(negedge clk_in);
    rob_clear_up = 1'b0;
    repeat (3) @(negedge clk_in);
    check("final_flush_beats", 32'(mem_log.size() - n0), 32'd4);
    check("final_flush_no_response", 32'(ready_cnt - r0), 32'd0);
    v = '{32'h0000_5068, 32'hBEEF_5068, 32'h0000_5068, 0, 32'h0000_5060, -1};
    do_fetch(v);

    // Flush in the cycle a hit would be accepted, then a new pc next cycle.
    n0 = mem_log.size();
    r0 = ready_cnt;
    pc = 32'h0000_1004;
    start_fetch = 1'b1;
    rob_clear_up = 1'b1;
    @(negedge clk_in);
    check_bit("flush_hit_suppressed", fetch_ready, 1'b0);
    rob_clear_up = 1'b0;
    pc = 32'h0000_2030;
    @(negedge clk_in);
    check_bit("post_flush_ready", fetch_ready, 1'b1);
    check("post_flush_inst", inst, 32'hBEEF_2030);
    check("post_flush_inst_addr", inst_addr, 32'h0000_2030);
    @(negedge clk_in);
    start_fetch = 1'b0;
    repeat (2) @(negedge clk_in);
    check("post_flush_pulses", 32'(ready_cnt - r0), 32'd1);
    check("post_flush_beats", 32'(mem_log.size() - n0), 32'd0);

    // Reset in the middle of a fill, then a previously cached line must miss.
    n0 = mem_log.size();
    pc = 32'h0000_6074;
    start_fetch = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_in);
      if (mem_log.size() == n0 + 1) found = 1'b1;
    end
    check_bit("rst_fill_started", found, 1'b1);
    rst_in = 1'b1;
    start_fetch = 1'b0;
    repeat (2) @(negedge clk_in);
    check_bit("midfill_rst_mem_req", mem_req, 1'b0);
    check("midfill_rst_mem_addr", mem_addr, 32'h0);
    check_bit("midfill_rst_fetch_ready", fetch_ready, 1'b0);
    rst_in = 1'b0;
    @(negedge clk_in);
    v = '{32'h0000_1004, 32'h0000_00A1, 32'h0000_1004, 4, 32'h0000_1000, -1};
    do_fetch(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
